// File: rtl/seq_divmul.sv
// Iterative signed/unsigned divider and multiplier.
// Operands are turned into magnitudes on entry, one result bit is produced
// per cycle, and the recorded signs are applied on exit.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start; operands and mode captured on Start
// LOAD  | form operand magnitudes, record signs, clear accumulator
// ITER  | WIDTH shift/subtract (divide) or add/shift (multiply) steps
// FIX   | apply sign correction, load Result/Remainder/DivZero
// DONE  | one-cycle Done pulse, back to IDLE
module seq_divmul #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Mode,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic               mode_q;
    logic               signed_q;
    logic [WIDTH-1:0]   op1_q;
    logic [WIDTH-1:0]   op2_q;
    // divisor magnitude (divide) or multiplicand magnitude (multiply)
    logic [WIDTH-1:0]   oper_q;
    // divide: {rem, dividend/quotient}; multiply: {high, multiplier/low}
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_res_q;
    logic               neg_rem_q;

    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_div;
    logic [2*WIDTH-1:0] acc_mul;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] prod_fix;

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        Busy      = 1'b0;
        Done      = 1'b0;
        unique case (state)
            S_IDLE: if (Start) state_nxt = S_LOAD;
            S_LOAD: begin
                Busy      = 1'b1;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                Busy = 1'b1;
                if (cnt_q == '0) state_nxt = S_FIX;
            end
            S_FIX: begin
                Busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Magnitudes, one iteration step for each mode, and exit sign correction.
    always_comb begin
        mag1 = (signed_q && op1_q[WIDTH-1]) ? (~op1_q + WIDTH'(1)) : op1_q;
        mag2 = (signed_q && op2_q[WIDTH-1]) ? (~op2_q + WIDTH'(1)) : op2_q;

        // The bit shifted out of the remainder half joins the trial subtract.
        trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, oper_q};
        if (!trial[WIDTH]) acc_div = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else               acc_div = {acc_q[2*WIDTH-2:0], 1'b0};

        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, oper_q} : '0);
        acc_mul = {sum, acc_q[WIDTH-1:1]};

        quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + WIDTH'(1))
                             : acc_q[2*WIDTH-1:WIDTH];
        prod_fix = neg_res_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    end

    // Datapath registers and result outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mode_q    <= 1'b0;
            signed_q  <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            oper_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            Result    <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        mode_q   <= Mode;
                        signed_q <= Signed;
                        op1_q    <= Operand1;
                        op2_q    <= Operand2;
                    end
                end
                S_LOAD: begin
                    acc_q     <= {{WIDTH{1'b0}}, (mode_q ? mag1 : mag2)};
                    oper_q    <= mode_q ? mag2 : mag1;
                    neg_res_q <= signed_q & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
                    neg_rem_q <= signed_q & op1_q[WIDTH-1];
                    cnt_q     <= CW'(WIDTH - 1);
                    DivZero   <= 1'b0;
                end
                S_ITER: begin
                    acc_q <= mode_q ? acc_div : acc_mul;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    if (mode_q) begin
                        if (op2_q == '0) begin
                            Result    <= '1;
                            Remainder <= op1_q;
                            DivZero   <= 1'b1;
                        end else begin
                            Result    <= quo_fix;
                            Remainder <= rem_fix;
                        end
                    end else begin
                        {Remainder, Result} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divmul.sv
// Self-checking bench for seq_divmul: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_seq_divmul;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Mode;
    logic         Signed;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic [W-1:0] Remainder;
    logic         DivZero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_divmul #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .Signed    (Signed),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .Remainder (Remainder),
        .DivZero   (DivZero)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic longint to_int(input bit s, input logic [W-1:0] v);
        logic signed [W-1:0] sv;
        sv = v;
        return s ? longint'(sv) : longint'(v);
    endfunction

    function automatic void model(input bit m, input bit s,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] rm,
                                  output bit dz);
        longint sa, sb, q, rr, p;
        logic [63:0] v;
        sa = to_int(s, a);
        sb = to_int(s, b);
        dz = 1'b0;
        if (m) begin
            if (b == '0) begin
                r  = '1;
                rm = a;
                dz = 1'b1;
            end else begin
                q  = sa / sb;
                rr = sa % sb;
                v  = q;
                r  = v[W-1:0];
                v  = rr;
                rm = v[W-1:0];
            end
        end else begin
            p  = sa * sb;
            v  = p;
            r  = v[W-1:0];
            rm = v[2*W-1:W];
        end
    endfunction

    // Runs one operation. poke_k >= 0 re-pulses Start at that sample;
    // rst_k >= 0 asserts Reset at that sample and checks the abort.
    task automatic do_op(input bit m, input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int poke_k, input int rst_k);
        logic [W-1:0] er, erm;
        bit           edz;
        int           k, dones;
        bit           busy_ok, finished;
        logic [W-1:0] hold_r, hold_rm;

        model(m, s, a, b, er, erm, edz);
        Mode = m; Signed = s; Operand1 = a; Operand2 = b; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        Mode = 1'($urandom); Signed = 1'($urandom);
        Operand1 = W'($urandom); Operand2 = W'($urandom);

        k = 0; dones = 0; busy_ok = 1'b1; finished = 1'b0;
        while (!finished && k < 40) begin
            if (Done) begin
                dones++;
                finished = 1'b1;
            end else begin
                if (!Busy) busy_ok = 1'b0;
                if (k == rst_k) begin
                    Reset = 1'b1;
                    @(posedge Clock); #1;
                    Reset = 1'b0;
                    check("rst_result", Result, 0);
                    check("rst_remainder", Remainder, 0);
                    check("rst_divzero", DivZero, 0);
                    check("rst_busy", Busy, 0);
                    check("rst_done", Done, 0);
                    for (int i = 0; i < W + 4; i++) begin
                        if (Done || Busy) dones++;
                        @(posedge Clock); #1;
                    end
                    check("rst_no_done", dones, 0);
                    return;
                end
                Start = (k == poke_k);
                if (k == poke_k) begin
                    Operand1 = W'($urandom); Operand2 = W'($urandom);
                    Mode = 1'($urandom);
                end
                @(posedge Clock); #1;
                k++;
            end
        end
        Start = 1'b0;
        check("done_seen", finished, 1);
        check("done_latency", k, W + 2);
        check("busy_until_done", busy_ok, 1);
        check("busy_at_done", Busy, 0);
        check("result", Result, er);
        check("remainder", Remainder, erm);
        check("divzero", DivZero, edz);
        hold_r = Result; hold_rm = Remainder;
        @(posedge Clock); #1;
        if (Done) dones++;
        check("done_count", dones, 1);
        check("hold_result", Result, er);
        check("hold_remainder", Remainder, erm);
        check("hold_divzero", DivZero, edz);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0; Signed = 1'b0;
        Operand1 = '0; Operand2 = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("init_result", Result, 0);
        check("init_remainder", Remainder, 0);
        check("init_divzero", DivZero, 0);
        check("init_busy", Busy, 0);
        check("init_done", Done, 0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        do_op(1'b1, 1'b0, 8'd200, 8'd7, -1, -1);
        do_op(1'b1, 1'b1, 8'hF9, 8'h02, -1, -1);
        do_op(1'b1, 1'b1, 8'h80, 8'hFF, -1, -1);
        do_op(1'b0, 1'b1, 8'hFD, 8'h05, -1, -1);
        do_op(1'b0, 1'b0, 8'hFF, 8'hFF, -1, -1);
        do_op(1'b0, 1'b1, 8'hFF, 8'hFF, -1, -1);
        do_op(1'b1, 1'b0, 8'd13, 8'd0, -1, -1);
        do_op(1'b1, 1'b0, 8'd9, 8'd3, -1, -1);
        do_op(1'b1, 1'b1, 8'd13, 8'd0, -1, -1);
        do_op(1'b1, 1'b0, 8'd50, 8'd6, 4, -1);
        do_op(1'b0, 1'b1, 8'h85, 8'h7B, 6, -1);
        do_op(1'b1, 1'b0, 8'd77, 8'd5, -1, 4);
        do_op(1'b1, 1'b0, 8'd100, 8'd10, -1, -1);

        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_op(1'($urandom), 1'($urandom), ra, rb, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
